// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: shared state encoding, command bytes and ball home position.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_LEFT  = 8'd108;
    localparam logic [7:0] CMD_RIGHT = 8'd114;
    localparam logic [7:0] CMD_HOLD  = 8'd100;
    localparam logic [7:0] CMD_START = 8'd115;
    localparam logic [7:0] CMD_PAUSE = 8'd112;

    localparam logic [9:0] BALL_HOME_X = 10'd320;
    localparam logic [8:0] BALL_HOME_Y = 9'd240;

endpackage

// File: rtl/game_ctrl_frame_tick.sv
// frame_tick: modulo-N frame_end counter with clear/hold and a terminal-count pulse.
module frame_tick #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_end,
    input  logic clear,
    input  logic hold,
    output logic tc
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt;

    assign tc = frame_end && !clear && !hold && (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (frame_end && !hold)
            cnt <= tc ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: UART command decode, paddle position, ball pacing and game FSM.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int TICK_FRAMES  = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int PAD_START    = 300,
    parameter int PAD_STEP     = 50,
    parameter int PAD_MIN      = 50,
    parameter int PAD_MAX      = 590,
    parameter int LIVES_INIT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       frame_end,
    input  logic       hit,
    input  logic       miss,
    output logic [9:0] paddle_x,
    output logic       update_en,
    output logic       ball_reset,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       game_over
);
    state_t     st, st_nx;
    logic [9:0] px_nx;
    logic [7:0] sc_nx;
    logic [1:0] lv_nx;
    logic       tick_tc, serve_tc;
    logic [10:0] px_w, px_sub_ok, px_add;
    logic [9:0]  px_left, px_right;

    wire cmd_l = rx_valid && (rx_data == CMD_LEFT);
    wire cmd_r = rx_valid && (rx_data == CMD_RIGHT);
    wire cmd_s = rx_valid && (rx_data == CMD_START);
    wire cmd_p = rx_valid && (rx_data == CMD_PAUSE);

    assign state     = st;
    // 11-bit arithmetic keeps the clamp free of wrap-around.
    assign px_w      = {1'b0, paddle_x};
    assign px_sub_ok = px_w - 11'(PAD_STEP);
    assign px_add    = px_w + 11'(PAD_STEP);
    assign px_left   = (px_w < 11'(PAD_MIN + PAD_STEP)) ? 10'(PAD_MIN) : px_sub_ok[9:0];
    assign px_right  = (px_add > 11'(PAD_MAX)) ? 10'(PAD_MAX) : px_add[9:0];

    frame_tick #(.N(TICK_FRAMES)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_end (frame_end),
        .clear     (st != S_RUN && st != S_PAUSE),
        .hold      (st == S_PAUSE),
        .tc        (tick_tc)
    );

    frame_tick #(.N(SERVE_FRAMES)) u_serve (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_end (frame_end),
        .clear     (st != S_SERVE),
        .hold      (1'b0),
        .tc        (serve_tc)
    );

    always_comb begin
        st_nx = st;
        sc_nx = score;
        lv_nx = lives;
        px_nx = (st == S_SERVE || st == S_RUN) ? (cmd_l ? px_left : cmd_r ? px_right : paddle_x) : paddle_x;
        if ((st == S_IDLE || st == S_OVER) && cmd_s) begin
            st_nx = S_SERVE;
            sc_nx = '0;
            lv_nx = 2'(LIVES_INIT);
            px_nx = 10'(PAD_START);
        end else if (st == S_SERVE && serve_tc) begin
            st_nx = S_RUN;
        end else if (st == S_RUN && miss) begin
            lv_nx = lives - 2'd1;
            st_nx = (lives == 2'd1) ? S_OVER : S_SERVE;
        end else if (st == S_RUN) begin
            sc_nx = (hit && score != 8'hff) ? score + 8'd1 : score;
            st_nx = cmd_p ? S_PAUSE : S_RUN;
        end else if (st == S_PAUSE && cmd_p) begin
            st_nx = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            paddle_x   <= 10'(PAD_START);
            score      <= '0;
            lives      <= 2'(LIVES_INIT);
            update_en  <= 1'b0;
            ball_reset <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            st         <= st_nx;
            paddle_x   <= px_nx;
            score      <= sc_nx;
            lives      <= lv_nx;
            update_en  <= tick_tc;
            ball_reset <= (st_nx == S_SERVE) && (st != S_SERVE);
            game_over  <= (st_nx == S_OVER);
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl with default parameters.
module tb_game_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       frame_end = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [9:0] paddle_x;
    logic       update_en, ball_reset, game_over;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] state;

    int passed = 0;
    int total = 0;
    int ue_cnt = 0;
    int br_cnt = 0;

    game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame_end  (frame_end),
        .hit        (hit),
        .miss       (miss),
        .paddle_x   (paddle_x),
        .update_en  (update_en),
        .ball_reset (ball_reset),
        .score      (score),
        .lives      (lives),
        .state      (state),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (update_en === 1'b1) ue_cnt++;
        if (ball_reset === 1'b1) br_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame(output logic ue);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        ue = update_en;
        @(negedge clk);
    endtask

    task automatic serve_out();
        logic ue;
        for (int i = 0; i < 60; i++) frame(ue);
    endtask

    initial begin
        logic ue;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_state", state, 0);
        chk("rst_paddle", paddle_x, 300);
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 3);
        chk("rst_update_en", update_en, 0);
        chk("rst_ball_reset", ball_reset, 0);
        chk("rst_game_over", game_over, 0);
        @(negedge clk) rst_n = 1'b1;

        send(8'd108);
        chk("idle_left", paddle_x, 300);
        send(8'd114);
        chk("idle_right", paddle_x, 300);
        chk("idle_state", state, 0);

        br_cnt = 0;
        send(8'd115);
        chk("start_state", state, 1);
        chk("start_ball_reset", ball_reset, 1);
        for (int i = 0; i < 6; i++) begin
            send(8'd108);
            chk("left_step", paddle_x, (i < 5) ? 250 - 50 * i : 50);
        end
        for (int i = 0; i < 12; i++) begin
            send(8'd114);
            chk("right_step", paddle_x, (i < 10) ? 100 + 50 * i : 590);
        end
        chk("ball_reset_once", br_cnt, 1);

        for (int i = 0; i < 59; i++) frame(ue);
        chk("serve_59", state, 1);
        frame(ue);
        chk("serve_60_run", state, 2);

        ue_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            frame(ue);
            chk("pace_ue", ue, (i % 3 == 2) ? 1 : 0);
        end
        chk("pace_count", ue_cnt, 3);

        frame(ue);
        frame(ue);
        chk("pre_pause_ue", ue, 0);
        send(8'd112);
        chk("pause_state", state, 3);
        ue_cnt = 0;
        for (int i = 0; i < 5; i++) frame(ue);
        chk("pause_no_ue", ue_cnt, 0);
        send(8'd108);
        chk("pause_paddle", paddle_x, 590);
        send(8'd112);
        chk("resume_state", state, 2);
        frame(ue);
        chk("resume_ue", ue, 1);
        chk("resume_count", ue_cnt, 1);

        hit = 1'b1;
        repeat (260) @(negedge clk);
        hit = 1'b0;
        chk("score_sat", score, 255);
        hit = 1'b1;
        miss = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        miss = 1'b0;
        chk("arb_score", score, 255);
        chk("arb_lives", lives, 2);
        chk("arb_state", state, 1);
        chk("arb_ball_reset", ball_reset, 1);

        serve_out();
        chk("serve2_run", state, 2);
        miss = 1'b1;
        @(negedge clk);
        miss = 1'b0;
        chk("miss2_lives", lives, 1);
        chk("miss2_state", state, 1);
        serve_out();
        miss = 1'b1;
        @(negedge clk);
        miss = 1'b0;
        chk("over_lives", lives, 0);
        chk("over_state", state, 4);
        chk("over_flag", game_over, 1);
        chk("over_score_held", score, 255);
        send(8'd108);
        chk("over_left_ignored", paddle_x, 590);
        send(8'd115);
        chk("new_state", state, 1);
        chk("new_score", score, 0);
        chk("new_lives", lives, 3);
        chk("new_paddle", paddle_x, 300);
        chk("new_game_over", game_over, 0);

        serve_out();
        hit = 1'b1;
        repeat (2) @(negedge clk);
        hit = 1'b0;
        send(8'd114);
        chk("pre_rst_score", score, 2);
        chk("pre_rst_paddle", paddle_x, 350);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_paddle", paddle_x, 300);
        chk("arst_score", score, 0);
        chk("arst_lives", lives, 3);
        @(negedge clk) rst_n = 1'b1;
        send(8'd120);
        chk("post_x_state", state, 0);
        chk("post_x_paddle", paddle_x, 300);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
